echo_heard_arbiter: RTL and testbench

ECHO_HEARD_ARBITER -- requirements
Module: echo_heard_arbiter

---
 rtl/echo_heard_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_echo_heard_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_heard_arbiter.sv
// echo_heard_arbiter
// Two clients each push {meth, v} pairs into a private 2-entry FIFO. A single
// output register presents one indication at a time on the heard_* port and is
// refilled from whichever FIFO wins a simple alternating arbitration. Per-client
// counters tally delivered indications.
//
// Timing notes:
//   - sayN__RDY is derived from registered occupancy only, so a dequeue in the
//     same cycle never opens the door for an extra enqueue.
//   - The output register refills in the same edge that its current contents
//     are accepted, which gives one indication per cycle under sustained load.
//   - Reset is synchronous; payload storage is intentionally left unreset.

module echo_heard_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  nRST,

    input  logic                  say0__ENA,
    input  logic [DATA_WIDTH-1:0] say0_meth,
    input  logic [DATA_WIDTH-1:0] say0_v,
    output logic                  say0__RDY,

    input  logic                  say1__ENA,
    input  logic [DATA_WIDTH-1:0] say1_meth,
    input  logic [DATA_WIDTH-1:0] say1_v,
    output logic                  say1__RDY,

    output logic                  heard__ENA,
    output logic [DATA_WIDTH-1:0] heard_meth,
    output logic [DATA_WIDTH-1:0] heard_v,
    output logic                  heard_client,
    input  logic                  heard__RDY,

    output logic [1:0]            occ0,
    output logic [1:0]            occ1,
    output logic [CNT_WIDTH-1:0]  grants0,
    output logic [CNT_WIDTH-1:0]  grants1
);

    // One FIFO entry packs meth in the upper half and v in the lower half.
    localparam int EW = 2 * DATA_WIDTH;

    // Per-client FIFO state, indexed [client][slot].
    logic [EW-1:0]         mem_q    [2][2];
    logic [1:0]            rd_ptr_q;
    logic [1:0]            rd_ptr_d;
    logic [1:0]            wr_ptr_q;
    logic [1:0]            wr_ptr_d;
    logic [1:0]            occ_q    [2];
    logic [1:0]            occ_d    [2];

    // FIFO handshake helpers.
    logic [1:0]            enq;
    logic [1:0]            deq;
    logic [1:0]            nonempty;
    logic [1:0]            not_full;
    logic [EW-1:0]         wdata    [2];
    logic [EW-1:0]         head     [2];

    // Output register and arbitration history.
    logic                  out_valid_q;
    logic                  out_valid_d;
    logic                  out_client_q;
    logic [DATA_WIDTH-1:0] out_meth_q;
    logic [DATA_WIDTH-1:0] out_v_q;
    logic                  last_grant_q;
    logic                  last_grant_d;

    logic                  load;
    logic                  sel;

    // Delivered-indication counters.
    logic [CNT_WIDTH-1:0]  grants_q [2];
    logic [CNT_WIDTH-1:0]  grants_d [2];
    logic [1:0]            heard_hit;

    // FIFO status, head selection and accepted enqueues.
    always_comb begin
        wdata[0] = {say0_meth, say0_v};
        wdata[1] = {say1_meth, say1_v};
        for (int c = 0; c < 2; c++) begin
            nonempty[c] = (occ_q[c] != 2'd0);
            not_full[c] = (occ_q[c] < 2'd2);
            head[c]     = mem_q[c][rd_ptr_q[c]];
        end
        // An ENA while the FIFO is full is dropped here rather than corrupting
        // the occupancy count.
        enq[0] = say0__ENA & not_full[0];
        enq[1] = say1__ENA & not_full[1];
    end

    // Arbitration: a lone non-empty FIFO wins outright; with both pending the
    // client that did not win the previous load goes next.
    always_comb begin
        sel = 1'b0;
        if (nonempty[0] && nonempty[1]) begin
            sel = ~last_grant_q;
        end else begin
            sel = nonempty[1];
        end
        load   = (~out_valid_q | heard__ENA) & (|nonempty);
        deq[0] = load & ~sel;
        deq[1] = load &  sel;
    end

    // Next-state for FIFO pointers/occupancy, output valid and grant history.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            occ_d[c]    = occ_q[c] + {1'b0, enq[c]} - {1'b0, deq[c]};
            wr_ptr_d[c] = wr_ptr_q[c] ^ enq[c];
            rd_ptr_d[c] = rd_ptr_q[c] ^ deq[c];
        end

        out_valid_d = out_valid_q;
        if (load) begin
            out_valid_d = 1'b1;
        end else if (heard__ENA) begin
            out_valid_d = 1'b0;
        end

        last_grant_d = load ? sel : last_grant_q;
    end

    // Counter next-state: bump the counter of whichever client was just heard.
    always_comb begin
        heard_hit[0] = heard__ENA & ~out_client_q;
        heard_hit[1] = heard__ENA &  out_client_q;
        for (int c = 0; c < 2; c++) begin
            grants_d[c] = grants_q[c] + {{(CNT_WIDTH-1){1'b0}}, heard_hit[c]};
        end
    end

    // Control state: FIFO pointers, occupancy, output valid, arbitration history.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            rd_ptr_q     <= 2'b00;
            wr_ptr_q     <= 2'b00;
            occ_q[0]     <= 2'd0;
            occ_q[1]     <= 2'd0;
            out_valid_q  <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            occ_q[0]     <= occ_d[0];
            occ_q[1]     <= occ_d[1];
            out_valid_q  <= out_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Counters clear on reset and wrap naturally at all-ones.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            grants_q[0] <= '0;
            grants_q[1] <= '0;
        end else begin
            grants_q[0] <= grants_d[0];
            grants_q[1] <= grants_d[1];
        end
    end

    // FIFO payload storage; no reset needed since occupancy gates every read.
    always_ff @(posedge CLK) begin
        for (int c = 0; c < 2; c++) begin
            if (nRST && enq[c]) begin
                mem_q[c][wr_ptr_q[c]] <= wdata[c];
            end
        end
    end

    // Output payload captures the winning head on each load and otherwise holds.
    always_ff @(posedge CLK) begin
        if (nRST && load) begin
            out_client_q <= sel;
            {out_meth_q, out_v_q} <= head[sel];
        end
    end

    assign say0__RDY    = not_full[0];
    assign say1__RDY    = not_full[1];

    assign heard__ENA   = out_valid_q & heard__RDY;
    assign heard_meth   = out_meth_q;
    assign heard_v      = out_v_q;
    assign heard_client = out_client_q;

    assign occ0         = occ_q[0];
    assign occ1         = occ_q[1];
    assign grants0      = grants_q[0];
    assign grants1      = grants_q[1];

endmodule

// File: tb/tb_echo_heard_arbiter.sv
// Bench for echo_heard_arbiter: directed scenarios plus a randomized run, all
// checked against a queue-based reference model of the arbiter.

module tb_echo_heard_arbiter;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          say0__ENA, say1__ENA;
    logic [DW-1:0] say0_meth, say0_v, say1_meth, say1_v;
    logic          say0__RDY, say1__RDY;
    logic          heard__ENA;
    logic [DW-1:0] heard_meth, heard_v;
    logic          heard_client;
    logic          heard__RDY;
    logic [1:0]    occ0, occ1;
    logic [CW-1:0] grants0, grants1;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    echo_heard_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .CLK(CLK), .nRST(nRST),
        .say0__ENA(say0__ENA), .say0_meth(say0_meth), .say0_v(say0_v), .say0__RDY(say0__RDY),
        .say1__ENA(say1__ENA), .say1_meth(say1_meth), .say1_v(say1_v), .say1__RDY(say1__RDY),
        .heard__ENA(heard__ENA), .heard_meth(heard_meth), .heard_v(heard_v),
        .heard_client(heard_client), .heard__RDY(heard__RDY),
        .occ0(occ0), .occ1(occ1), .grants0(grants0), .grants1(grants1)
    );

    // Reference model: each client is a bounded queue of {meth, v}; the held
    // indication is a single slot; counters are plain modulo-16 tallies.
    logic [63:0]   mq0[$];
    logic [63:0]   mq1[$];
    bit            m_hv;
    bit            m_hc;
    logic [63:0]   m_hd;
    bit            m_last;
    logic [CW-1:0] m_g0, m_g1;

    function automatic void model_edge(input bit e0, input logic [63:0] d0,
                                       input bit e1, input logic [63:0] d1,
                                       input bit rdy, input bit rst_n);
        bit acc0, acc1, taken;
        if (!rst_n) begin
            mq0.delete(); mq1.delete();
            m_hv = 0; m_last = 1; m_g0 = 0; m_g1 = 0;
            return;
        end
        acc0  = e0 && (mq0.size() < 2);
        acc1  = e1 && (mq1.size() < 2);
        taken = m_hv && rdy;
        if (taken) begin
            if (m_hc) m_g1 = m_g1 + 1'b1;
            else      m_g0 = m_g0 + 1'b1;
        end
        if (!m_hv || taken) begin
            // Alternate when both wait; otherwise serve whoever has something.
            if (mq0.size() > 0 && (mq1.size() == 0 || m_last == 1)) begin
                m_hd = mq0.pop_front(); m_hc = 0; m_hv = 1; m_last = 0;
            end else if (mq1.size() > 0) begin
                m_hd = mq1.pop_front(); m_hc = 1; m_hv = 1; m_last = 1;
            end else begin
                m_hv = 0;
            end
        end
        if (acc0) mq0.push_back(d0);
        if (acc1) mq1.push_back(d1);
    endfunction

    // Drive one cycle of inputs from the falling edge, advance the model at
    // the rising edge, then park with ENAs low just past the next falling edge.
    task automatic tick(input bit e0, input logic [63:0] d0,
                        input bit e1, input logic [63:0] d1,
                        input bit rdy, input bit rst_n);
        say0__ENA = e0; {say0_meth, say0_v} = d0;
        say1__ENA = e1; {say1_meth, say1_v} = d1;
        heard__RDY = rdy; nRST = rst_n;
        @(posedge CLK);
        model_edge(e0, d0, e1, d1, rdy, rst_n);
        @(negedge CLK);
        say0__ENA = 1'b0; say1__ENA = 1'b0;
        #1;
    endtask

    task automatic idle(input bit rdy);
        tick(1'b0, 64'd0, 1'b0, 64'd0, rdy, 1'b1);
    endtask

    task automatic do_reset();
        tick(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
        tick(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (occ0 !== 2'd0) begin errors++; $display("FAIL reset_occ0: got %0d want 0", occ0); end
        checks++; if (occ1 !== 2'd0) begin errors++; $display("FAIL reset_occ1: got %0d want 0", occ1); end
        checks++; if (say0__RDY !== 1'b1) begin errors++; $display("FAIL reset_rdy0: got %0b want 1", say0__RDY); end
        checks++; if (say1__RDY !== 1'b1) begin errors++; $display("FAIL reset_rdy1: got %0b want 1", say1__RDY); end
        heard__RDY = 1'b1; #1;
        checks++; if (heard__ENA !== 1'b0) begin errors++; $display("FAIL reset_ena: got %0b want 0", heard__ENA); end
        checks++; if (grants0 !== 4'd0 || grants1 !== 4'd0) begin errors++; $display("FAIL reset_grants: got %0d/%0d want 0/0", grants0, grants1); end
    endtask

    task automatic test_single();
        do_reset();
        tick(1'b1, {32'h11, 32'h22}, 1'b0, 64'd0, 1'b1, 1'b1);
        checks++; if (occ0 !== 2'd1) begin errors++; $display("FAIL single_occ0: got %0d want 1", occ0); end
        checks++; if (heard__ENA !== 1'b0) begin errors++; $display("FAIL single_early_ena: got %0b want 0", heard__ENA); end
        idle(1'b1);
        checks++; if (heard__ENA !== 1'b1) begin errors++; $display("FAIL single_ena: got %0b want 1", heard__ENA); end
        checks++; if (heard_meth !== 32'h11 || heard_v !== 32'h22) begin errors++; $display("FAIL single_data: got %h/%h want 11/22", heard_meth, heard_v); end
        checks++; if (heard_client !== 1'b0) begin errors++; $display("FAIL single_client: got %0b want 0", heard_client); end
        idle(1'b1);
        checks++; if (heard__ENA !== 1'b0) begin errors++; $display("FAIL single_idle_ena: got %0b want 0", heard__ENA); end
        checks++; if (grants0 !== 4'd1) begin errors++; $display("FAIL single_grants0: got %0d want 1", grants0); end
    endtask

    task automatic test_fairness();
        logic [31:0] exp_m [4];
        bit          exp_c [4];
        exp_m[0] = 32'hA0; exp_m[1] = 32'hB0; exp_m[2] = 32'hA1; exp_m[3] = 32'hB1;
        exp_c[0] = 0;      exp_c[1] = 1;      exp_c[2] = 0;      exp_c[3] = 1;
        do_reset();
        tick(1'b1, {32'hA0, 32'h1A0}, 1'b1, {32'hB0, 32'h1B0}, 1'b1, 1'b1);
        tick(1'b1, {32'hA1, 32'h1A1}, 1'b1, {32'hB1, 32'h1B1}, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (heard__ENA !== 1'b1 || heard_client !== exp_c[i] || heard_meth !== exp_m[i]) begin
                errors++;
                $display("FAIL fair_order[%0d]: got ena=%0b c=%0b m=%h want ena=1 c=%0b m=%h",
                         i, heard__ENA, heard_client, heard_meth, exp_c[i], exp_m[i]);
            end
            idle(1'b1);
        end
        checks++; if (heard__ENA !== 1'b0) begin errors++; $display("FAIL fair_idle: got %0b want 0", heard__ENA); end
        checks++; if (grants0 !== 4'd2 || grants1 !== 4'd2) begin errors++; $display("FAIL fair_grants: got %0d/%0d want 2/2", grants0, grants1); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_m [5];
        exp_m[0] = 32'hC0; exp_m[1] = 32'hD0; exp_m[2] = 32'hE0; exp_m[3] = 32'hD1; exp_m[4] = 32'hE1;
        do_reset();
        tick(1'b1, {32'hC0, 32'h0}, 1'b0, 64'd0, 1'b0, 1'b1);
        idle(1'b0);
        tick(1'b1, {32'hE0, 32'h0}, 1'b1, {32'hD0, 32'h0}, 1'b0, 1'b1);
        tick(1'b1, {32'hE1, 32'h0}, 1'b1, {32'hD1, 32'h0}, 1'b0, 1'b1);
        checks++; if (occ0 !== 2'd2 || occ1 !== 2'd2) begin errors++; $display("FAIL bp_occ: got %0d/%0d want 2/2", occ0, occ1); end
        checks++; if (say0__RDY !== 1'b0 || say1__RDY !== 1'b0) begin errors++; $display("FAIL bp_rdy: got %0b/%0b want 0/0", say0__RDY, say1__RDY); end
        for (int i = 0; i < 3; i++) begin
            // ENA while full must be ignored and must not disturb the held output.
            tick(1'b1, {32'hBAD, 32'hBAD}, 1'b1, {32'hBAD, 32'hBAD}, 1'b0, 1'b1);
            checks++;
            if (heard__ENA !== 1'b0 || heard_meth !== 32'hC0 || heard_client !== 1'b0 || occ0 !== 2'd2 || occ1 !== 2'd2) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got ena=%0b m=%h c=%0b occ=%0d/%0d want ena=0 m=c0 c=0 occ=2/2",
                         i, heard__ENA, heard_meth, heard_client, occ0, occ1);
            end
            checks++; if (grants0 !== 4'd0 || grants1 !== 4'd0) begin errors++; $display("FAIL bp_grants[%0d]: got %0d/%0d want 0/0", i, grants0, grants1); end
        end
        heard__RDY = 1'b1; #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (heard__ENA !== 1'b1 || heard_meth !== exp_m[i]) begin
                errors++;
                $display("FAIL bp_drain[%0d]: got ena=%0b m=%h want ena=1 m=%h", i, heard__ENA, heard_meth, exp_m[i]);
            end
            idle(1'b1);
        end
        checks++; if (heard__ENA !== 1'b0) begin errors++; $display("FAIL bp_idle: got %0b want 0", heard__ENA); end
        checks++; if (grants0 !== 4'd3 || grants1 !== 4'd2) begin errors++; $display("FAIL bp_final_grants: got %0d/%0d want 3/2", grants0, grants1); end
    endtask

    task automatic test_full_dequeue();
        do_reset();
        tick(1'b1, {32'hF0, 32'h0}, 1'b0, 64'd0, 1'b0, 1'b1);
        idle(1'b0);
        tick(1'b1, {32'hF1, 32'h0}, 1'b0, 64'd0, 1'b0, 1'b1);
        tick(1'b1, {32'hF2, 32'h0}, 1'b0, 64'd0, 1'b0, 1'b1);
        checks++; if (occ0 !== 2'd2 || say0__RDY !== 1'b0) begin errors++; $display("FAIL fd_full: got occ=%0d rdy=%0b want 2/0", occ0, say0__RDY); end
        idle(1'b1);
        checks++; if (occ0 !== 2'd1 || say0__RDY !== 1'b1) begin errors++; $display("FAIL fd_after: got occ=%0d rdy=%0b want 1/1", occ0, say0__RDY); end
        checks++; if (heard_meth !== 32'hF1) begin errors++; $display("FAIL fd_next_head: got %h want f1", heard_meth); end
    endtask

    task automatic test_midop_reset();
        do_reset();
        tick(1'b1, {32'h50, 32'h0}, 1'b0, 64'd0, 1'b0, 1'b1);
        idle(1'b0);
        tick(1'b1, {32'h51, 32'h0}, 1'b1, {32'h60, 32'h0}, 1'b0, 1'b1);
        tick(1'b1, {32'h52, 32'h0}, 1'b0, 64'd0, 1'b0, 1'b1);
        checks++; if (occ0 !== 2'd2 || occ1 !== 2'd1 || heard_meth !== 32'h50) begin errors++; $display("FAIL mr_setup: got occ=%0d/%0d m=%h want 2/1 m=50", occ0, occ1, heard_meth); end
        tick(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
        heard__RDY = 1'b1; #1;
        checks++; if (occ0 !== 2'd0 || occ1 !== 2'd0 || heard__ENA !== 1'b0) begin errors++; $display("FAIL mr_cleared: got occ=%0d/%0d ena=%0b want 0/0 ena=0", occ0, occ1, heard__ENA); end
        tick(1'b0, 64'd0, 1'b1, {32'h77, 32'h78}, 1'b1, 1'b1);
        checks++; if (heard__ENA !== 1'b0) begin errors++; $display("FAIL mr_no_stale: got %0b want 0", heard__ENA); end
        idle(1'b1);
        checks++; if (heard__ENA !== 1'b1 || heard_meth !== 32'h77 || heard_v !== 32'h78 || heard_client !== 1'b1) begin
            errors++; $display("FAIL mr_new: got ena=%0b m=%h v=%h c=%0b want 1 77 78 1", heard__ENA, heard_meth, heard_v, heard_client);
        end
        for (int i = 0; i < 2; i++) begin
            idle(1'b1);
            checks++; if (heard__ENA !== 1'b0) begin errors++; $display("FAIL mr_quiet[%0d]: got %0b want 0", i, heard__ENA); end
        end
        checks++; if (grants0 !== 4'd0 || grants1 !== 4'd1) begin errors++; $display("FAIL mr_grants: got %0d/%0d want 0/1", grants0, grants1); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 14; i++) tick(1'b0, 64'd0, 1'b1, {$urandom, $urandom}, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1);
        checks++; if (grants1 !== 4'd14) begin errors++; $display("FAIL wrap_pre: got %0d want 14", grants1); end
        tick(1'b0, 64'd0, 1'b1, 64'd1, 1'b1, 1'b1); idle(1'b1); idle(1'b1);
        checks++; if (grants1 !== 4'd15) begin errors++; $display("FAIL wrap_15: got %0d want 15", grants1); end
        tick(1'b0, 64'd0, 1'b1, 64'd2, 1'b1, 1'b1); idle(1'b1); idle(1'b1);
        checks++; if (grants1 !== 4'd0) begin errors++; $display("FAIL wrap_0: got %0d want 0", grants1); end
        checks++; if (grants0 !== 4'd0) begin errors++; $display("FAIL wrap_g0: got %0d want 0", grants0); end
    endtask

    task automatic test_random();
        bit e0, e1, rdy, rst_n;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            e0    = ($urandom_range(0, 2) != 0);
            e1    = ($urandom_range(0, 2) != 0);
            rdy   = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 149) != 0);
            tick(e0, {$urandom, $urandom}, e1, {$urandom, $urandom}, rdy, rst_n);
            checks++; if (heard__ENA !== (m_hv && heard__RDY)) begin errors++; $display("FAIL rnd_ena[%0d]: got %0b want %0b", n, heard__ENA, m_hv && heard__RDY); end
            if (m_hv) begin
                checks++;
                if (heard_client !== m_hc || {heard_meth, heard_v} !== m_hd) begin
                    errors++;
                    $display("FAIL rnd_out[%0d]: got c=%0b d=%h want c=%0b d=%h", n, heard_client, {heard_meth, heard_v}, m_hc, m_hd);
                end
            end
            checks++; if (occ0 !== 2'(mq0.size()) || occ1 !== 2'(mq1.size())) begin errors++; $display("FAIL rnd_occ[%0d]: got %0d/%0d want %0d/%0d", n, occ0, occ1, mq0.size(), mq1.size()); end
            checks++; if (say0__RDY !== (mq0.size() < 2) || say1__RDY !== (mq1.size() < 2)) begin errors++; $display("FAIL rnd_rdy[%0d]: got %0b/%0b", n, say0__RDY, say1__RDY); end
            checks++; if (grants0 !== m_g0 || grants1 !== m_g1) begin errors++; $display("FAIL rnd_grants[%0d]: got %0d/%0d want %0d/%0d", n, grants0, grants1, m_g0, m_g1); end
        end
    endtask

    initial begin
        nRST = 1'b0; heard__RDY = 1'b0;
        say0__ENA = 1'b0; say0_meth = '0; say0_v = '0;
        say1__ENA = 1'b0; say1_meth = '0; say1_v = '0;
        @(negedge CLK);
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_full_dequeue();
        test_midop_reset();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
